// File: rtl/xc_malu_pkg.sv
// Shared constants for the MALU step sequencer: one-hot op and pack-width
// bit positions, FSM state encoding and the default step limit.
package xc_malu_pkg;

   localparam int OPW_DEF       = 10;
   localparam int PWW_DEF       = 5;
   localparam int MAX_STEPS_DEF = 40;

   localparam int OP_DIV    = 0;
   localparam int OP_DIVU   = 1;
   localparam int OP_REM    = 2;
   localparam int OP_REMU   = 3;
   localparam int OP_MUL    = 4;
   localparam int OP_MULU   = 5;
   localparam int OP_MULSU  = 6;
   localparam int OP_CLMUL  = 7;
   localparam int OP_PMUL   = 8;
   localparam int OP_PCLMUL = 9;

   localparam int PW_32 = 0;
   localparam int PW_16 = 1;
   localparam int PW_8  = 2;
   localparam int PW_4  = 3;
   localparam int PW_2  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/xc_malu_seq.sv
// Sequencer and state-register owner for the combinational MALU step engine:
// accepts a request, iterates the engine once per cycle, returns the result.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high unless flushing
// RUN   | engine iterating on latched operands, one step per cycle
// DONE  | result/error held on rsp_* until rsp_ack
module xc_malu_seq
   import xc_malu_pkg::*;
#(
   parameter int OPW       = OPW_DEF,
   parameter int PWW       = PWW_DEF,
   parameter int MAX_STEPS = MAX_STEPS_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [OPW-1:0]  req_op,
   input  logic [PWW-1:0]  req_pw,
   input  logic [31:0]     req_rs1,
   input  logic [31:0]     req_rs2,
   input  logic [31:0]     req_rs3,
   input  logic            flush,
   output logic            rsp_valid,
   input  logic            rsp_ack,
   output logic [63:0]     rsp_result,
   output logic            rsp_err,
   output logic            eng_valid,
   output logic            eng_flush,
   output logic [OPW-1:0]  eng_op,
   output logic [PWW-1:0]  eng_pw,
   output logic [31:0]     eng_rs1,
   output logic [31:0]     eng_rs2,
   output logic [31:0]     eng_rs3,
   output logic [5:0]      count,
   output logic [63:0]     acc,
   output logic [31:0]     arg_0,
   output logic [31:0]     arg_1,
   input  logic [63:0]     n_acc,
   input  logic [31:0]     n_arg_0,
   input  logic [31:0]     n_arg_1,
   input  logic            eng_ready,
   input  logic [63:0]     eng_result
);

   localparam logic [5:0] LAST_STEP = 6'(MAX_STEPS - 1);

   state_e          state_q;
   logic [OPW-1:0]  op_q;
   logic [PWW-1:0]  pw_q;
   logic [31:0]     rs1_q, rs2_q, rs3_q;
   logic [5:0]      count_q;
   logic [63:0]     acc_q;
   logic [31:0]     arg_0_q, arg_1_q;
   logic [63:0]     result_q;
   logic            err_q;
   logic            op_onehot;

   assign op_onehot = (req_op != '0) && ((req_op & (req_op - 1'b1)) == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         pw_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rs3_q    <= '0;
         count_q  <= '0;
         acc_q    <= '0;
         arg_0_q  <= '0;
         arg_1_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else if (flush) begin
         // Latched operands survive a flush; only the iteration state is dropped.
         state_q  <= ST_IDLE;
         count_q  <= '0;
         acc_q    <= '0;
         arg_0_q  <= '0;
         arg_1_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  pw_q    <= req_pw;
                  rs1_q   <= req_rs1;
                  rs2_q   <= req_rs2;
                  rs3_q   <= req_rs3;
                  count_q <= '0;
                  acc_q   <= '0;
                  arg_0_q <= req_rs1;
                  arg_1_q <= '0;
                  if (op_onehot) begin
                     state_q <= ST_RUN;
                  end else begin
                     state_q  <= ST_DONE;
                     result_q <= '0;
                     err_q    <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (eng_ready) begin
                  state_q  <= ST_DONE;
                  result_q <= eng_result;
                  err_q    <= 1'b0;
               end else if (count_q == LAST_STEP) begin
                  state_q  <= ST_DONE;
                  result_q <= '0;
                  err_q    <= 1'b1;
               end else begin
                  acc_q   <= n_acc;
                  arg_0_q <= n_arg_0;
                  arg_1_q <= n_arg_1;
                  count_q <= count_q + 6'd1;
               end
            end
            ST_DONE: begin
               if (rsp_ack) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == ST_IDLE) && !flush;
   assign rsp_valid  = (state_q == ST_DONE);
   assign eng_valid  = (state_q == ST_RUN);
   assign eng_flush  = flush;
   assign rsp_result = result_q;
   assign rsp_err    = err_q;
   assign eng_op     = op_q;
   assign eng_pw     = pw_q;
   assign eng_rs1    = rs1_q;
   assign eng_rs2    = rs2_q;
   assign eng_rs3    = rs3_q;
   assign count      = count_q;
   assign acc        = acc_q;
   assign arg_0      = arg_0_q;
   assign arg_1      = arg_1_q;

endmodule

// File: tb/tb_xc_malu_seq.sv
// Bench for xc_malu_seq with an accumulate-by-arg_0 stub engine and a
// response scoreboard; DUT outputs sampled and inputs driven on the falling edge.
module tb_xc_malu_seq;
   import xc_malu_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_op;
   logic [4:0]  req_pw;
   logic [31:0] req_rs1, req_rs2, req_rs3;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ack;
   logic [63:0] rsp_result;
   logic        rsp_err;
   logic        eng_valid, eng_flush;
   logic [9:0]  eng_op;
   logic [4:0]  eng_pw;
   logic [31:0] eng_rs1, eng_rs2, eng_rs3;
   logic [5:0]  count;
   logic [63:0] acc;
   logic [31:0] arg_0, arg_1;
   logic [63:0] n_acc;
   logic [31:0] n_arg_0, n_arg_1;
   logic        eng_ready;
   logic [63:0] eng_result;

   logic        never_ready;
   logic [5:0]  ready_at;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [64:0] sb_q[$];
   int          seen_counts[$];

   always #5 clock = ~clock;

   assign n_acc      = acc + {32'b0, arg_0};
   assign n_arg_0    = arg_0;
   assign n_arg_1    = arg_1;
   assign eng_ready  = !never_ready && (count == ready_at);
   assign eng_result = acc;

   xc_malu_seq dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_pw(req_pw),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
      .flush(flush),
      .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
      .rsp_result(rsp_result), .rsp_err(rsp_err),
      .eng_valid(eng_valid), .eng_flush(eng_flush),
      .eng_op(eng_op), .eng_pw(eng_pw),
      .eng_rs1(eng_rs1), .eng_rs2(eng_rs2), .eng_rs3(eng_rs3),
      .count(count), .acc(acc), .arg_0(arg_0), .arg_1(arg_1),
      .n_acc(n_acc), .n_arg_0(n_arg_0), .n_arg_1(n_arg_1),
      .eng_ready(eng_ready), .eng_result(eng_result)
   );

   // Called on the falling edge right after the accept edge; lat counts
   // cycles with the accept cycle as cycle 0.
   task automatic wait_rsp(input int max_cyc, output int lat, output bit timed_out);
      lat = 1;
      while (!rsp_valid && lat < max_cyc) begin
         if (eng_valid) seen_counts.push_back(int'(count));
         @(negedge clock);
         lat++;
      end
      timed_out = !rsp_valid;
   endtask

   task automatic issue(input logic [9:0] op, input logic [31:0] rs1,
                        input logic [64:0] expect_rsp);
      req_valid = 1'b1;
      req_op    = op;
      req_pw    = 5'b00001;
      req_rs1   = rs1;
      req_rs2   = rs1 ^ 32'hA5A5_0000;
      req_rs3   = ~rs1;
      sb_q.push_back(expect_rsp);
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic do_ack();
      rsp_ack = 1'b1;
      @(negedge clock);
      rsp_ack = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || eng_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b eng_valid=%b, want 1 0 0",
                  req_ready, rsp_valid, eng_valid);
      end
      n_checks++;
      if (count !== 6'd0 || acc !== 64'd0 || arg_0 !== 32'd0 || arg_1 !== 32'd0 ||
          eng_rs1 !== 32'd0 || eng_op !== 10'd0 || rsp_result !== 64'd0 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_regs: count=%0d acc=%0h arg_0=%0h eng_rs1=%0h eng_op=%0h res=%0h err=%b, want all 0",
                  count, acc, arg_0, eng_rs1, eng_op, rsp_result, rsp_err);
      end
   endtask

   task automatic test_basic();
      int lat; bit to;
      logic [64:0] exp;
      logic [63:0] held;
      never_ready = 1'b0; ready_at = 6'd3;
      seen_counts.delete();
      issue(10'b1 << OP_MUL, 32'd5, {1'b0, 64'd15});
      wait_rsp(20, lat, to);
      n_checks++;
      if (to || lat != 5) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d (timeout=%b), want 5", lat, to);
      end
      n_checks++;
      if (seen_counts.size() != 4 || seen_counts[0] != 0 || seen_counts[1] != 1 ||
          seen_counts[2] != 2 || seen_counts[3] != 3) begin
         n_fail++;
         $display("FAIL basic_counts: got %p, want 0 1 2 3", seen_counts);
      end
      exp = sb_q.pop_front();
      n_checks++;
      if (rsp_result !== exp[63:0] || rsp_err !== exp[64]) begin
         n_fail++;
         $display("FAIL basic_result: got %0d err=%b, want %0d err=%b",
                  rsp_result, rsp_err, exp[63:0], exp[64]);
      end
      held = rsp_result;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_result !== held || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold[%0d]: valid=%b res=%0d ready=%b, want 1 %0d 0",
                     i, rsp_valid, rsp_result, req_ready, held);
         end
      end
      rsp_ack = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_same_cycle_ready: got %b, want 0", req_ready);
      end
      @(negedge clock);
      rsp_ack = 1'b0;
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_next_ready: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_overrun();
      int lat; bit to;
      logic [64:0] exp;
      never_ready = 1'b1;
      seen_counts.delete();
      issue(10'b1 << OP_DIV, 32'd3, {1'b1, 64'd0});
      wait_rsp(100, lat, to);
      n_checks++;
      if (to || seen_counts.size() != 40 || seen_counts[$] != 39) begin
         n_fail++;
         $display("FAIL overrun_cycles: run cycles=%0d timeout=%b, want 40", seen_counts.size(), to);
      end
      exp = sb_q.pop_front();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp[63:0] || rsp_err !== exp[64]) begin
         n_fail++;
         $display("FAIL overrun_result: valid=%b res=%0h err=%b, want 1 %0h %b",
                  rsp_valid, rsp_result, rsp_err, exp[63:0], exp[64]);
      end
      do_ack();
      never_ready = 1'b0;
   endtask

   task automatic test_flush();
      bit seen_valid;
      never_ready = 1'b0; ready_at = 6'd2;
      issue(10'b1 << OP_REM, 32'd4, {1'b0, 64'd8});
      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if (count !== 6'd2 || eng_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_setup: count=%0d eng_ready=%b, want 2 1", count, eng_ready);
      end
      flush = 1'b1;
      req_valid = 1'b1;
      #1;
      n_checks++;
      if (eng_flush !== 1'b1 || req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_comb: eng_flush=%b req_ready=%b, want 1 0", eng_flush, req_ready);
      end
      @(negedge clock);
      flush = 1'b0;
      req_valid = 1'b0;
      void'(sb_q.pop_front());
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || eng_valid !== 1'b0 || req_ready !== 1'b1 ||
          acc !== 64'd0 || count !== 6'd0 || eng_flush !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_after: valid=%b eng_valid=%b ready=%b acc=%0d count=%0d eng_flush=%b, want 0 0 1 0 0 0",
                  rsp_valid, eng_valid, req_ready, acc, count, eng_flush);
      end
      seen_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (rsp_valid || eng_valid) seen_valid = 1'b1;
      end
      n_checks++;
      if (seen_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_discard: activity after flush=%b, want 0", seen_valid);
      end
   endtask

   task automatic test_back_to_back();
      int lat; bit to; bit rs1_stable;
      logic [64:0] exp;
      never_ready = 1'b0; ready_at = 6'd3;
      req_valid = 1'b1; req_op = 10'b1 << OP_MULU; req_pw = 5'b00010;
      req_rs1 = 32'd7; req_rs2 = 32'd1; req_rs3 = 32'd2;
      sb_q.push_back({1'b0, 64'd21});
      @(negedge clock);
      req_rs1 = 32'd9;
      rs1_stable = 1'b1;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         if (eng_rs1 !== 32'd7) rs1_stable = 1'b0;
         @(negedge clock);
         lat++;
      end
      for (int i = 0; i < 2; i++) begin
         if (eng_rs1 !== 32'd7 || req_ready !== 1'b0) rs1_stable = 1'b0;
         @(negedge clock);
      end
      n_checks++;
      if (!rs1_stable || !rsp_valid) begin
         n_fail++;
         $display("FAIL b2b_hold: eng_rs1 stable=%b valid=%b, want 1 1", rs1_stable, rsp_valid);
      end
      exp = sb_q.pop_front();
      n_checks++;
      if (rsp_result !== exp[63:0] || rsp_err !== exp[64]) begin
         n_fail++;
         $display("FAIL b2b_first: got %0d err=%b, want %0d err=%b",
                  rsp_result, rsp_err, exp[63:0], exp[64]);
      end
      rsp_ack = 1'b1;
      @(negedge clock);
      rsp_ack = 1'b0;
      sb_q.push_back({1'b0, 64'd27});
      n_checks++;
      if (req_ready !== 1'b1 || eng_rs1 !== 32'd7) begin
         n_fail++;
         $display("FAIL b2b_idle: ready=%b eng_rs1=%0d, want 1 7", req_ready, eng_rs1);
      end
      @(negedge clock);
      req_valid = 1'b0;
      n_checks++;
      if (eng_rs1 !== 32'd9 || eng_valid !== 1'b1 || eng_pw !== 5'b00010) begin
         n_fail++;
         $display("FAIL b2b_second_accept: eng_rs1=%0d eng_valid=%b eng_pw=%b, want 9 1 00010",
                  eng_rs1, eng_valid, eng_pw);
      end
      wait_rsp(20, lat, to);
      exp = sb_q.pop_front();
      n_checks++;
      if (to || rsp_result !== exp[63:0] || rsp_err !== exp[64]) begin
         n_fail++;
         $display("FAIL b2b_second: got %0d err=%b timeout=%b, want %0d err=%b",
                  rsp_result, rsp_err, to, exp[63:0], exp[64]);
      end
      do_ack();
   endtask

   task automatic test_reset_mid_and_bad_op();
      logic [64:0] exp;
      never_ready = 1'b0; ready_at = 6'd3;
      issue(10'b1 << OP_PMUL, 32'd6, {1'b0, 64'd18});
      @(negedge clock);
      n_checks++;
      if (eng_valid !== 1'b1 || acc === 64'd0) begin
         n_fail++;
         $display("FAIL rst_mid_setup: eng_valid=%b acc=%0d, want 1 nonzero", eng_valid, acc);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      sb_q.delete();
      n_checks++;
      if (count !== 6'd0 || acc !== 64'd0 || arg_0 !== 32'd0 || eng_rs1 !== 32'd0 ||
          eng_rs3 !== 32'd0 || eng_op !== 10'd0 || rsp_valid !== 1'b0 || eng_valid !== 1'b0 ||
          req_ready !== 1'b1 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid: count=%0d acc=%0d arg_0=%0d rs1=%0d op=%0h valid=%b eng_valid=%b ready=%b, want reset values",
                  count, acc, arg_0, eng_rs1, eng_op, rsp_valid, eng_valid, req_ready);
      end
      issue(10'b0, 32'd11, {1'b1, 64'd0});
      exp = sb_q.pop_front();
      n_checks++;
      if (rsp_valid !== 1'b1 || eng_valid !== 1'b0 || rsp_result !== exp[63:0] || rsp_err !== exp[64]) begin
         n_fail++;
         $display("FAIL bad_op_zero: valid=%b eng_valid=%b res=%0d err=%b, want 1 0 %0d %b",
                  rsp_valid, eng_valid, rsp_result, rsp_err, exp[63:0], exp[64]);
      end
      do_ack();
      issue(10'b0000110000, 32'd11, {1'b1, 64'd0});
      exp = sb_q.pop_front();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp[63:0] || rsp_err !== exp[64]) begin
         n_fail++;
         $display("FAIL bad_op_multi: valid=%b res=%0d err=%b, want 1 %0d %b",
                  rsp_valid, rsp_result, rsp_err, exp[63:0], exp[64]);
      end
      do_ack();
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_pw = '0;
      req_rs1 = '0; req_rs2 = '0; req_rs3 = '0;
      flush = 1'b0; rsp_ack = 1'b0;
      never_ready = 1'b0; ready_at = 6'd3;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_overrun();
      test_flush();
      test_back_to_back();
      test_reset_mid_and_bad_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
